// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants, opcode enum and sequencer state type for the ALU sequencer.
package alu_sequencer_pkg;

  localparam logic [2:0] kADD     = 3'b000;
  localparam logic [2:0] kLSH     = 3'b001;
  localparam logic [2:0] kRSH     = 3'b010;
  localparam logic [2:0] kXOR     = 3'b011;
  localparam logic [2:0] kAND     = 3'b100;
  localparam logic [2:0] kSUB     = 3'b101;
  localparam logic [2:0] kCLR     = 3'b110;
  localparam logic [2:0] kILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    OP_ADD = kADD,
    OP_LSH = kLSH,
    OP_RSH = kRSH,
    OP_XOR = kXOR,
    OP_AND = kAND,
    OP_SUB = kSUB,
    OP_CLR = kCLR,
    OP_ILL = kILLEGAL
  } op_name;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    DONE
  } seq_state_t;

  function automatic logic isShift(input op_name op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: arithmetic/logic ops and single-bit shifts; shifts report the bit pushed out.
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  op_name       op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry
);

  always_comb begin
    // NOTE: default every output first so no path through the case can infer a latch.
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_LSH: begin
        result = {a[W-2:0], 1'b0};
        carry  = a[W-1];
      end
      OP_RSH: begin
        result = {1'b0, a[W-1:1]};
        carry  = a[0];
      end
      OP_XOR: result = a ^ b;
      OP_AND: result = a & b;
      OP_CLR: result = '0;
      OP_ILL: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-command ALU sequencer: accepts one command, executes it (multi-cycle for shifts),
// then holds the response until the consumer takes it.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  seq_state_t       stateQ;
  op_name           opQ;
  logic [W-1:0]     workQ;
  logic [W-1:0]     operandBQ;
  logic [CNT_W-1:0] cntQ;
  logic             carryQ;
  logic             rspValidQ;
  logic [W-1:0]     rspDataQ;
  logic             rspCarryQ;
  logic             rspZeroQ;
  logic             rspErrQ;

  logic [W-1:0]     aluResult;
  logic             aluCarry;
  op_name           cmdOp;

  assign cmdOp = op_name'(cmd_op);

  alu_sequencer_alu #(.W(W)) alu (
    .op     (opQ),
    .a      (workQ),
    .b      (operandBQ),
    .result (aluResult),
    .carry  (aluCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      opQ       <= OP_ADD;
      workQ     <= '0;
      operandBQ <= '0;
      cntQ      <= '0;
      carryQ    <= 1'b0;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
      rspCarryQ <= 1'b0;
      rspZeroQ  <= 1'b1;
      rspErrQ   <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      case (stateQ)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opQ       <= cmdOp;
            workQ     <= cmd_a;
            operandBQ <= cmd_b;
            cntQ      <= cmd_cnt;
            carryQ    <= 1'b0;
            stateQ    <= (isShift(cmdOp) && (cmd_cnt != '0)) ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          // A zero-count shift passes operand A through with carry cleared.
          if (!isShift(opQ)) begin
            workQ  <= aluResult;
            carryQ <= aluCarry;
          end
          stateQ <= DONE;
        end
        SHIFT: begin
          workQ  <= aluResult;
          carryQ <= aluCarry;
          cntQ   <= cntQ - CNT_W'(1);
          if (cntQ == CNT_W'(1)) stateQ <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; it then stays frozen until taken.
          if (!rspValidQ) begin
            rspValidQ <= 1'b1;
            rspDataQ  <= workQ;
            rspCarryQ <= carryQ;
            rspZeroQ  <= (workQ == '0);
            rspErrQ   <= (opQ == OP_ILL);
          end else if (rsp_ready) begin
            rspValidQ <= 1'b0;
            stateQ    <= IDLE;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (stateQ == IDLE);
  assign busy      = (stateQ != IDLE);
  assign rsp_valid = rspValidQ;
  assign rsp_data  = rspDataQ;
  assign rsp_carry = rspCarryQ;
  assign rsp_zero  = rspZeroQ;
  assign rsp_err   = rspErrQ;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: W, 8, datapath width in bits.
REQ-002 SHALL have parameter: CNT_W, 3, width of shift-count field.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: cmd_valid  input  1  command request.
REQ-006 SHALL have port: cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port: cmd_op  input  3  opcode, op_name encoding (ADD 000, LSH 001, RSH 010, XOR 011, AND 100, SUB 101, CLR 110).
REQ-008 SHALL have port: cmd_a  input  W  operand A.
REQ-009 SHALL have port: cmd_b  input  W  operand B.
REQ-010 SHALL have port: cmd_cnt  input  CNT_W  shift amount (LSH/RSH only).
REQ-011 SHALL have port: rsp_valid  output  1  result available.
REQ-012 SHALL have port: rsp_ready  input  1  consumer takes result.
REQ-013 SHALL have port: rsp_data  output  W  result.
REQ-014 SHALL have port: rsp_carry  output  1  carry / borrow / last shifted-out bit.
REQ-015 SHALL have port: rsp_zero  output  1  rsp_data == 0.
REQ-016 SHALL have port: rsp_err  output  1  opcode 3'b111 received.
REQ-017 SHALL have port: busy  output  1  state != IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, SHIFT, DONE.
REQ-019 SHALL assert cmd_ready only in IDLE; command accepted on edge where cmd_valid && cmd_ready; cmd_a/b/op/cnt registered at that edge, ignored otherwise.
REQ-020 SHALL, on accept of ADD/XOR/AND/SUB/CLR/111, or LSH/RSH with cmd_cnt=0, go IDLE->EXEC; EXEC computes and registers result, go DONE; rsp_valid high after edge T+2 (T = accept edge) -- i.e. one cycle in EXEC.
REQ-021 SHALL, on accept of LSH/RSH with cmd_cnt=N>0, go IDLE->SHIFT; apply one 1-bit ALU shift per cycle, N cycles, then DONE; rsp_valid high after edge T+N+1.
REQ-022 SHALL fill shifts with 0; rsp_carry = bit shifted out on final iteration; cmd_cnt=0 gives rsp_data=cmd_a, rsp_carry=0.
REQ-023 SHALL compute ADD mod 2^W with rsp_carry = carry-out; SUB = A-B mod 2^W with rsp_carry = 1 iff A<B; XOR/AND bitwise with rsp_carry=0; CLR rsp_data=0, rsp_carry=0.
REQ-024 SHALL treat opcode 3'b111 as: rsp_data=0, rsp_carry=0, rsp_err=1; rsp_err=0 for all other opcodes.
REQ-025 SHALL set rsp_zero = (rsp_data == 0) for every opcode.
REQ-026 SHALL, in DONE, hold rsp_valid=1 and rsp_data/carry/zero/err stable until rsp_ready=1; on that edge go IDLE; no same-cycle new accept (cmd_ready rises the cycle after).
REQ-027 SHALL keep cmd_ready=0 in EXEC/SHIFT/DONE regardless of cmd_valid; no command queuing.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE immediately (asynchronous), including mid-EXEC/SHIFT/DONE; in-flight command discarded, no response.
REQ-029 SHALL present reset values: cmd_ready=1 after rst_n deasserts, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=1, rsp_err=0, busy=0, shift counter=0.
REQ-030 SHALL accept no command while rst_n=0.

Structure
REQ-031 SHALL place opcode constants (kADD..CLR), op_name enum, FSM state enum seq_state_t, and 3'b111 illegal-op constant in package definition.
REQ-032 SHALL instantiate one combinational sub-module alu (inputs op, a, b; outputs result, carry), doing single-bit LSH/RSH; sequencer owns all registers.

Verification
REQ-033 ADD a=0xF0 b=0x20 -> rsp_data=0x10, carry=1, zero=0, rsp_valid after edge T+2.
REQ-034 SUB 0x05-0x05 -> 0x00, zero=1, carry=0; SUB 0x03-0x05 -> 0xFE, carry=1.
REQ-035 LSH a=0x81 cnt=3 -> 0x08, carry=0, rsp_valid after edge T+4; RSH a=0x81 cnt=1 -> 0x40, carry=1; LSH cnt=0 -> 0x81, carry=0.
REQ-036 rsp_ready=0 for 5 cycles after XOR 0xAA^0xFF -> rsp_valid/rsp_data=0x55 stable, cmd_ready=0, concurrent cmd_valid not accepted; accepted cycle after rsp handshake.
REQ-037 rst_n low during 3rd iteration of LSH cnt=7 -> rsp_valid=0, busy=0 immediately; after release, AND 0x0F&0x3C -> 0x0C correct.
REQ-038 opcode 3'b111 a=0x12 -> rsp_data=0x00, rsp_err=1, zero=1; next ADD -> rsp_err=0.
